stopwatch_dp: RTL and testbench



---
 rtl/stopwatch_dp_pkg.sv | 38 +++
 rtl/stopwatch_digit_cnt.sv | 38 +++
 rtl/stopwatch_dp.sv | 89 ++++++++
 tb/tb_stopwatch_dp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_dp_pkg.sv
// stopwatch_defs: shared definitions for the stopwatch datapath.
//   mode_e        - decoded operating mode of the datapath
//   DEF_*_MAX     - default moduli of the four time fields
//   DEF_TICK_DIV  - default prescale (100 MHz clk down to a 100 Hz tick)
//   *_W           - field widths for centiseconds/seconds/minutes/hours
//   decode_mode() - priority decode of the control-unit level inputs
package stopwatch_defs;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_UP    = 2'd1,
      MODE_DOWN  = 2'd2,
      MODE_CLEAR = 2'd3
   } mode_e;

   localparam int DEF_TICK_DIV = 1_000_000;
   localparam int DEF_MSEC_MAX = 100;
   localparam int DEF_SEC_MAX  = 60;
   localparam int DEF_MIN_MAX  = 60;
   localparam int DEF_HOUR_MAX = 24;

   localparam int MSEC_W = 7;
   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   // clear beats run beats count-down; illegal combinations resolve here
   function automatic mode_e decode_mode(input logic clear, input logic runstop,
                                         input logic count_down);
      mode_e m;
      if (clear)           m = MODE_CLEAR;
      else if (runstop)    m = MODE_UP;
      else if (count_down) m = MODE_DOWN;
      else                 m = MODE_HOLD;
      return m;
   endfunction

endpackage

// File: rtl/stopwatch_digit_cnt.sv
// stopwatch_digit_cnt: one modulo-MAX up/down field of the stopwatch cascade.
//   clk, rst  - clock, synchronous active-high reset
//   i_clear   - load 0 on the next edge
//   i_tick    - advance one step this cycle (previous stage's o_carry)
//   i_down    - direction: 1 = decrement, 0 = increment
//   o_val     - current field value, always 0..MAX-1
//   o_carry   - combinational; i_tick and the field wraps in the current direction
module stopwatch_digit_cnt #(
   parameter int MAX = 10,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clear,
   input  logic         i_tick,
   input  logic         i_down,
   output logic [W-1:0] o_val,
   output logic         o_carry
);

   logic [W-1:0] val;
   logic         wrap;

   // wrap point: 0 when counting down, MAX-1 when counting up
   assign wrap    = i_down ? (val == '0) : (val == W'(MAX - 1));
   assign o_carry = i_tick & wrap;
   assign o_val   = val;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         val <= '0;
      end else if (i_tick) begin
         if (i_down) val <= wrap ? W'(MAX - 1) : val - 1'b1;
         else        val <= wrap ? '0          : val + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_dp.sv
// stopwatch_dp: stopwatch datapath. Prescales clk to a centisecond tick and
// keeps a cascaded hour:min:sec:centisecond value counting up or down.
//   clk, rst      - clock, synchronous active-high reset
//   i_runstop     - level; count up while high
//   i_clear       - level; zero time and prescaler while high
//   i_count_down  - level; count down while high
//   o_msec/o_sec/o_min/o_hour - time fields
//   o_zero        - all fields zero (combinational from the field registers)
//   o_done        - registered one-cycle pulse when a count-down lands on zero
module stopwatch_dp
   import stopwatch_defs::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int MSEC_MAX = DEF_MSEC_MAX,
   parameter int SEC_MAX  = DEF_SEC_MAX,
   parameter int MIN_MAX  = DEF_MIN_MAX,
   parameter int HOUR_MAX = DEF_HOUR_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_runstop,
   input  logic              i_clear,
   input  logic              i_count_down,
   output logic [MSEC_W-1:0] o_msec,
   output logic [SEC_W-1:0]  o_sec,
   output logic [MIN_W-1:0]  o_min,
   output logic [HOUR_W-1:0] o_hour,
   output logic              o_zero,
   output logic              o_done
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   mode_e         mode;
   logic          run, down, clr;
   logic [PW-1:0] presc;
   logic          presc_wrap, tick;
   logic          c_msec, c_sec, c_min, hour_wrap_unused;
   logic          at_one;

   assign mode = decode_mode(i_clear, i_runstop, i_count_down);
   assign run  = (mode == MODE_UP) || (mode == MODE_DOWN);
   assign down = (mode == MODE_DOWN);
   assign clr  = (mode == MODE_CLEAR);

   // prescaler only moves while running, so a partial tick survives HOLD
   // and a direction change
   assign presc_wrap = run && (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr)      presc <= '0;
      else if (presc_wrap) presc <= '0;
      else if (run)        presc <= presc + 1'b1;
   end

   // counting down from all-zero would underflow into 23:59:59.99; block it
   assign tick = presc_wrap && !(down && o_zero);

   stopwatch_digit_cnt #(.MAX(MSEC_MAX), .W(MSEC_W)) u_msec (
      .clk(clk), .rst(rst), .i_clear(clr), .i_tick(tick), .i_down(down),
      .o_val(o_msec), .o_carry(c_msec)
   );

   stopwatch_digit_cnt #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
      .clk(clk), .rst(rst), .i_clear(clr), .i_tick(c_msec), .i_down(down),
      .o_val(o_sec), .o_carry(c_sec)
   );

   stopwatch_digit_cnt #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clk(clk), .rst(rst), .i_clear(clr), .i_tick(c_sec), .i_down(down),
      .o_val(o_min), .o_carry(c_min)
   );

   // hour wrap has no consumer: 23:59:59.99 + 1 silently rolls to zero
   stopwatch_digit_cnt #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
      .clk(clk), .rst(rst), .i_clear(clr), .i_tick(c_min), .i_down(down),
      .o_val(o_hour), .o_carry(hour_wrap_unused)
   );

   assign o_zero = (o_msec == '0) && (o_sec == '0) && (o_min == '0) && (o_hour == '0);
   assign at_one = (o_msec == MSEC_W'(1)) && (o_sec == '0) && (o_min == '0) && (o_hour == '0);

   // clear/reset force mode away from DOWN, which also kills a pending pulse
   always_ff @(posedge clk) begin
      if (rst) o_done <= 1'b0;
      else     o_done <= down && tick && at_one;
   end

endmodule

// File: tb/tb_stopwatch_dp.sv
// tb_stopwatch_dp: directed stimulus with a cycle-tagged expectation queue.
// Stimulus pushes expected field values tagged with the cycle they must be
// visible on; an independent monitor pops and compares on each falling edge.
// A second instance with tiny moduli and TICK_DIV=1 exercises the full
// hour-wrap cascade within a short run.
module tb_stopwatch_dp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_runstop = 1'b0, i_clear = 1'b0, i_count_down = 1'b0;
   logic [6:0] o_msec;
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hour;
   logic       o_zero, o_done;

   logic       w_runstop = 1'b0;
   logic [6:0] w_msec;
   logic [5:0] w_sec, w_min;
   logic [4:0] w_hour;
   logic       w_zero, w_done;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stopwatch_dp #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .i_runstop(i_runstop), .i_clear(i_clear),
      .i_count_down(i_count_down), .o_msec(o_msec), .o_sec(o_sec),
      .o_min(o_min), .o_hour(o_hour), .o_zero(o_zero), .o_done(o_done)
   );

   stopwatch_dp #(.TICK_DIV(1), .MSEC_MAX(4), .SEC_MAX(3), .MIN_MAX(3), .HOUR_MAX(2)) dut_w (
      .clk(clk), .rst(rst), .i_runstop(w_runstop), .i_clear(1'b0),
      .i_count_down(1'b0), .o_msec(w_msec), .o_sec(w_sec),
      .o_min(w_min), .o_hour(w_hour), .o_zero(w_zero), .o_done(w_done)
   );

   typedef struct {
      int    at;
      int    sel;
      int    h, m, s, ms;
      bit    z, d;
      string nm;
   } exp_t;

   exp_t q[$];

   task automatic push(input int k, input int sel, input int h, input int m,
                       input int s, input int ms, input bit z, input bit d,
                       input string nm);
      exp_t e;
      e.at = cyc + k; e.sel = sel;
      e.h = h; e.m = m; e.s = s; e.ms = ms; e.z = z; e.d = d; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic drive(input logic rs, input logic ru, input logic cl, input logic dn);
      rst = rs; i_runstop = ru; i_clear = cl; i_count_down = dn;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor
   always @(negedge clk) begin : mon
      exp_t e;
      int   gh, gm, gs, gms;
      bit   gz, gd;
      while (q.size() > 0 && q[0].at <= cyc) begin
         e = q.pop_front();
         if (e.sel == 0) begin
            gh = o_hour; gm = o_min; gs = o_sec; gms = o_msec; gz = o_zero; gd = o_done;
         end else begin
            gh = w_hour; gm = w_min; gs = w_sec; gms = w_msec; gz = w_zero; gd = w_done;
         end
         checks++;
         if (e.at != cyc || gh != e.h || gm != e.m || gs != e.s || gms != e.ms ||
             gz != e.z || gd != e.d) begin
            failures++;
            $display("FAIL %s cyc=%0d/%0d got %0d:%0d:%0d.%0d z=%0d d=%0d expected %0d:%0d:%0d.%0d z=%0d d=%0d",
                     e.nm, cyc, e.at, gh, gm, gs, gms, gz, gd, e.h, e.m, e.s, e.ms, e.z, e.d);
         end
      end
   end

   initial begin
      // reset
      @(negedge clk);
      push(1, 0, 0, 0, 0, 0, 1, 0, "reset");
      wait_n(1);

      // first tick lands on the 4th enabled edge
      drive(0, 1, 0, 0);
      for (int k = 1; k <= 3; k++) push(k, 0, 0, 0, 0, 0, 1, 0, "up_pre_tick");
      push(4, 0, 0, 0, 0, 1, 0, 0, "up_first_tick");
      // 5998 more ticks to 00:00:59.99, one more carries into minutes
      push(23996, 0, 0, 0, 59, 99, 0, 0, "up_to_59_99");
      push(24000, 0, 0, 1, 0, 0, 0, 0, "carry_into_min");
      wait_n(24000);

      // borrow through all three lower fields
      drive(0, 0, 0, 1);
      push(1, 0, 0, 1, 0, 0, 0, 0, "down_pre_tick");
      push(4, 0, 0, 0, 59, 99, 0, 0, "down_borrow");
      wait_n(4);

      drive(0, 0, 1, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "clear");
      wait_n(1);

      // count down to zero: one done pulse, then stuck at zero
      drive(0, 1, 0, 0);
      push(8, 0, 0, 0, 0, 2, 0, 0, "up_to_02");
      wait_n(8);
      drive(0, 0, 0, 1);
      for (int k = 1; k <= 3; k++)  push(k, 0, 0, 0, 0, 2, 0, 0, "down_02");
      for (int k = 4; k <= 7; k++)  push(k, 0, 0, 0, 0, 1, 0, 0, "down_01");
      push(8, 0, 0, 0, 0, 0, 1, 1, "done_pulse");
      for (int k = 9; k <= 16; k++) push(k, 0, 0, 0, 0, 0, 1, 0, "zero_no_underflow");
      wait_n(16);

      // partial tick kept across a stop
      drive(0, 0, 1, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "clear2");
      wait_n(1);
      drive(0, 1, 0, 0);
      push(2, 0, 0, 0, 0, 0, 1, 0, "run_two");
      wait_n(2);
      drive(0, 0, 0, 0);
      push(10, 0, 0, 0, 0, 0, 1, 0, "hold_ten");
      wait_n(10);
      drive(0, 1, 0, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "resume_1");
      push(2, 0, 0, 0, 0, 1, 0, 0, "resume_2");
      wait_n(2);

      // clear on the same edge as the final down tick
      drive(0, 0, 1, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "clear3");
      wait_n(1);
      drive(0, 1, 0, 0);
      push(8, 0, 0, 0, 0, 2, 0, 0, "up_to_02b");
      wait_n(8);
      drive(0, 0, 0, 1);
      push(4, 0, 0, 0, 0, 1, 0, 0, "down_01b");
      push(7, 0, 0, 0, 0, 1, 0, 0, "down_01b_presc3");
      wait_n(7);
      drive(0, 0, 1, 1);
      push(1, 0, 0, 0, 0, 0, 1, 0, "clear_vs_tick");
      wait_n(1);
      drive(0, 0, 0, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "clear_no_done");
      wait_n(1);

      // same with reset
      drive(0, 0, 1, 0);
      wait_n(1);
      drive(0, 1, 0, 0);
      push(8, 0, 0, 0, 0, 2, 0, 0, "up_to_02c");
      wait_n(8);
      drive(0, 0, 0, 1);
      push(7, 0, 0, 0, 0, 1, 0, 0, "down_01c_presc3");
      wait_n(7);
      drive(1, 0, 0, 1);
      push(1, 0, 0, 0, 0, 0, 1, 0, "rst_vs_tick");
      wait_n(1);
      drive(0, 0, 0, 0);
      push(1, 0, 0, 0, 0, 0, 1, 0, "rst_no_done");
      wait_n(1);

      // full cascade wrap on the small instance: period 4*3*3*2 = 72 ticks
      w_runstop = 1'b1;
      push(1, 1, 0, 0, 0, 1, 0, 0, "w_first");
      push(71, 1, 1, 2, 2, 3, 0, 0, "w_max");
      push(72, 1, 0, 0, 0, 0, 1, 0, "w_wrap_no_done");
      wait_n(72);
      w_runstop = 1'b0;

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         failures += q.size();
         $display("FAIL drain pending=%0d expected 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
